sm_add_sub_pipe: RTL and testbench
==================================

Name: sm_add_sub_pipe

Overview:
- Parametrised, pipelined sign-magnitude adder/subtractor for the core ALU. Supersedes the fixed 8-bit combinational sign-magnitude adder.
- New over the predecessor: operand width parameter, runtime add/sub select, overflow detection with optional saturation, negative-zero normalisation, and a two-stage pipeline with valid/ready backpressure on both sides.
- Magnitude arithmetic uses a parallel-prefix adder sub-module.

Parameters:
- W, 8: total word width (sign bit plus W-1 magnitude bits); W >= 3.
- SAT, 1: 1 = saturate magnitude to all-ones on overflow; 0 = wrap (drop the carry-out).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  W  operand A; [W-1] is the sign, [W-2:0] is the magnitude.
- b  in  W  operand B; same format.
- op  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  sign-magnitude result.
- ovf  out  1  magnitude overflow occurred; qualified by out_valid.

Behaviour:
- Reset, asynchronous on rst_n low:
  - s1_valid, s2_valid, out_valid, sum and ovf all go to 0.
  - in_ready is 1 whenever no stage is stalled, so it reads 1 during and after reset.
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Stage 1, on accept, registers:
  - effective sign_b = b[W-1] ^ op.
  - max/min magnitudes, chosen with a strict greater-than compare of A's magnitude against B's.
  - result sign = sign of the larger magnitude; when magnitudes are equal, take the effective sign of B.
  - eff_sub = sign_a ^ effective sign_b.
- Stage 2 (the output register) computes, using the prefix adder:
  - Addition (eff_sub = 0): mag = max + min. Carry-out marks overflow.
  - Subtraction (eff_sub = 1): mag = max + ~min + 1. The carry-out is discarded and overflow is always 0.
  - On overflow: if SAT=1, mag is all-ones; if SAT=0, mag is the low W-1 bits. ovf = 1 in both cases.
  - Zero normalisation: if mag == 0, the sign is forced to 0. Negative zero is never emitted.
- Latency: 2 cycles from input accept to out_valid, with no stalls.
- Throughput: 1 result per cycle while out_ready = 1.
- Pipeline advance rules:
  - Stage 2 loads when !s2_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || stage 2 loads. It is combinational from out_ready, and that is the only combinational path.
- Stall: with out_ready = 0, sum, ovf and out_valid hold stable. Results are never dropped or duplicated.
- Simultaneous accept and drain in the same cycle is legal. All stages shift together.
- Input capture: a, b and op are captured only on accept. Changes while in_valid = 0 or in_ready = 0 have no effect.
- Reset mid-operation: in-flight results are discarded and no spurious out_valid follows reset release.

Decomposition:
- Shared package sm_arith_pkg:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - a helper function that splits a word into sign and magnitude.
- Sub-module ppa_n:
  - purely combinational, parameter N (= W-1).
  - ports a, b, cin, S, cout; Kogge-Stone prefix network.
  - generalises the existing 8-bit prefix adder.
  - instantiated once, in stage 2.

Test Plan (all cases W=8 unless noted):
- Reset and mixed signs: assert rst_n = 0 with traffic in flight, then release; then send a=0x05, b=0x83, op=0, out_ready=1.
  - During reset: out_valid = 0 and no output is produced.
  - After release: sum=0x02, ovf=0, out_valid exactly 2 cycles after accept.
- Subtract and zero: a=0x03, b=0x05, op=1 -> sum=0x82 (-2). Then a=0x85, b=0x85, op=1 -> sum=0x00, not 0x80.
- Overflow with SAT=1: a=0x64, b=0x32, op=0 -> sum=0x7F, ovf=1. Same operands with SAT=0 -> sum=0x16, ovf=1. Negative case a=0xE4, b=0xB2 with SAT=1 -> sum=0xFF, ovf=1.
- Backpressure: stream 5 ops with out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts.
  - sum and ovf stay stable while stalled.
  - After release, all 5 results appear in order with none lost.
- Full throughput: back-to-back random ops, in_valid=1 and out_ready=1 for 1000 cycles.
  - One result per cycle.
  - Every result matches the scoreboard model.
  - Repeat at W=16 and W=3.
- Out_ready toggling every cycle alongside random in_valid: ordering is preserved, and accept/drain in the same cycle works.

Source files
------------

// File: rtl/sm_arith_pkg.sv
// sm_arith_pkg: shared op encoding and sign-magnitude word helpers
package sm_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int   MAX_W  = 64;

    typedef struct packed {
        logic [MAX_W-2:0] mag;
        logic             sign;
    } sm_split_t;

    function automatic sm_split_t sm_split(input logic [MAX_W-1:0] w, input int width);
        sm_split_t r;
        r.sign = |(w & (MAX_W'(1) << (width - 1)));
        r.mag  = w[MAX_W-2:0] & ({(MAX_W-1){1'b1}} >> (MAX_W - width));
        return r;
    endfunction

endpackage

// File: rtl/ppa_n.sv
// ppa_n: N-bit Kogge-Stone parallel-prefix adder with carry-in
module ppa_n #(
    parameter int N = 7
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout
);
    localparam int L  = $clog2(N);
    localparam int DL = 1 << (L - 1);

    logic [N-1:0] g_top;

    for (genvar k = 0; k < L; k++) begin : lvl
        logic [N-1:0] g, p;
        if (k == 0) begin : g_init
            assign p = a ^ b;
            assign g = (a & b) | N'(p[0] & cin);
        end else begin : g_step
            localparam int D = 1 << (k - 1);
            assign g = lvl[k-1].g | (lvl[k-1].p & (lvl[k-1].g << D));
            assign p = lvl[k-1].p & (lvl[k-1].p << D);
        end
    end

    assign g_top = lvl[L-1].g | (lvl[L-1].p & (lvl[L-1].g << DL));
    assign S     = lvl[0].p ^ {g_top[N-2:0], cin};
    assign cout  = g_top[N-1];

endmodule

// File: rtl/sm_add_sub_pipe.sv
// sm_add_sub_pipe: two-stage sign-magnitude add/sub with overflow handling and valid/ready flow control
module sm_add_sub_pipe
    import sm_arith_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         ovf
);
    localparam int M = W - 1;

    logic         sign_a, sign_b, sign_be, a_gt;
    logic [M-1:0] mag_a, mag_b;
    logic         s1_valid, s1_sign, s1_eff_sub;
    logic [M-1:0] s1_max, s1_min;
    logic         s1_load, s2_load;
    logic [M-1:0] add_s, mag;
    logic         add_cout, ovf_d;

    // sm_split packs sign at the LSB so a width cast keeps exactly {mag, sign}
    assign {mag_a, sign_a} = W'(sm_split(MAX_W'(a), W));
    assign {mag_b, sign_b} = W'(sm_split(MAX_W'(b), W));
    assign sign_be  = sign_b ^ (op == OP_SUB);
    assign a_gt     = mag_a > mag_b;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_max     <= '0;
            s1_min     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= a_gt ? sign_a : sign_be;
                s1_eff_sub <= sign_a ^ sign_be;
                s1_max     <= a_gt ? mag_a : mag_b;
                s1_min     <= a_gt ? mag_b : mag_a;
            end
        end
    end

    ppa_n #(.N(M)) u_ppa (
        .a    (s1_max),
        .b    (s1_eff_sub ? ~s1_min : s1_min),
        .cin  (s1_eff_sub),
        .S    (add_s),
        .cout (add_cout)
    );

    assign ovf_d = !s1_eff_sub && add_cout;
    assign mag   = (ovf_d && SAT) ? '1 : add_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum <= {s1_sign && (mag != '0), mag};
                ovf <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_sm_add_sub_pipe.sv
// tb_sm_add_sub_pipe: scoreboard bench over four width/saturation configurations
module tb_sm_add_sub_pipe;

    typedef struct {
        logic [7:0] a, b;
        logic       op;
        logic [7:0] s_sat, s_wrap;
        logic       ovf;
    } vec_t;
    typedef logic [3:0][16:0] exp_t;

    int wt[4] = '{8, 8, 16, 3};
    bit st[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, op;
    logic [15:0] a_r[4], b_r[4];
    logic [3:0]  ir, ov, of;
    logic [7:0]  sum0, sum1;
    logic [15:0] sum2;
    logic [2:0]  sum3;

    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    exp_t q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    sm_add_sub_pipe #(.W(8), .SAT(1'b1)) u_w8s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a_r[0][7:0]), .b(b_r[0][7:0]), .op(op), .out_valid(ov[0]),
        .out_ready(out_ready), .sum(sum0), .ovf(of[0]));
    sm_add_sub_pipe #(.W(8), .SAT(1'b0)) u_w8w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a_r[1][7:0]), .b(b_r[1][7:0]), .op(op), .out_valid(ov[1]),
        .out_ready(out_ready), .sum(sum1), .ovf(of[1]));
    sm_add_sub_pipe #(.W(16), .SAT(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a_r[2]), .b(b_r[2]), .op(op), .out_valid(ov[2]),
        .out_ready(out_ready), .sum(sum2), .ovf(of[2]));
    sm_add_sub_pipe #(.W(3), .SAT(1'b1)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .a(a_r[3][2:0]), .b(b_r[3][2:0]), .op(op), .out_valid(ov[3]),
        .out_ready(out_ready), .sum(sum3), .ovf(of[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Signed-integer reference: value arithmetic, then clamp or wrap the magnitude
    function automatic logic [16:0] ref_model(int w, bit sat, logic [15:0] a, logic [15:0] b, logic sub);
        int mx, va, vb, r, m;
        bit s, o;
        mx = (1 << (w - 1)) - 1;
        va = int'(a) & mx;
        vb = int'(b) & mx;
        if (((int'(a) >> (w - 1)) & 1) != 0) va = -va;
        if (((int'(b) >> (w - 1)) & 1) != 0) vb = -vb;
        r = sub ? va - vb : va + vb;
        m = (r < 0) ? -r : r;
        o = m > mx;
        if (o) m = sat ? mx : (m & mx);
        s = (r < 0) && (m != 0);
        return {o, 16'(m | (s ? (1 << (w - 1)) : 0))};
    endfunction

    function automatic logic [15:0] sum_of(int i);
        return (i == 0) ? 16'(sum0) : (i == 1) ? 16'(sum1) : (i == 2) ? sum2 : 16'(sum3);
    endfunction

    always @(negedge clk) begin : mon
        exp_t e, n;
        if (!rst_n) q.delete();
        else begin
            if (ov[0] && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 32'(ov[0]), 32'(0));
                else begin
                    e = q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("result_w%0d_sat%0d", wt[i], st[i]),
                            {15'd0, of[i], sum_of(i)}, {15'd0, e[i]});
                        chk($sformatf("valid_w%0d_sat%0d", wt[i], st[i]), 32'(ov[i]), 32'(1));
                    end
                    n_out++;
                end
            end
            if (in_valid && ir[0]) begin
                for (int i = 0; i < 4; i++) n[i] = ref_model(wt[i], st[i], a_r[i], b_r[i], op);
                q.push_back(n);
            end
        end
    end

    task automatic rnd_inputs();
        for (int i = 0; i < 4; i++) begin
            a_r[i] = 16'($urandom);
            b_r[i] = 16'($urandom);
        end
        op = 1'($urandom);
    endtask

    task automatic drain();
        int c = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        #1 chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    task automatic send_dir(input vec_t v);
        int n;
        @(posedge clk); #1;
        rnd_inputs();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = v.op;
        a_r[0]    = 16'(v.a);
        a_r[1]    = 16'(v.a);
        b_r[0]    = 16'(v.b);
        b_r[1]    = 16'(v.b);
        @(negedge clk);
        chk("dir_in_ready", 32'(ir[0]), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!ov[0] && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk("dir_latency", 32'(n), 32'(2));
        chk("dir_sum_sat", 32'(sum0), 32'(v.s_sat));
        chk("dir_sum_wrap", 32'(sum1), 32'(v.s_wrap));
        chk("dir_ovf_sat", 32'(of[0]), 32'(v.ovf));
        chk("dir_ovf_wrap", 32'(of[1]), 32'(v.ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, sent, acc, both, stall;
        logic [7:0] hold_s;
        logic       hold_o;
        tbl[0] = '{8'h05, 8'h83, 1'b0, 8'h02, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b1, 8'h82, 8'h82, 1'b0};
        tbl[2] = '{8'h85, 8'h85, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{8'h64, 8'h32, 1'b0, 8'h7F, 8'h16, 1'b1};
        tbl[4] = '{8'hE4, 8'hB2, 1'b0, 8'hFF, 8'h96, 1'b1};
        tbl[5] = '{8'h40, 8'h40, 1'b0, 8'h7F, 8'h00, 1'b1};
        tbl[6] = '{8'h80, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 8'h7E, 1'b1};
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rnd_inputs();
        #2;
        chk("reset_out_valid", 32'(ov), 32'(0));
        chk("reset_in_ready", 32'(ir), 32'hF);
        chk("reset_sum", 32'(sum0), 32'(0));
        chk("reset_ovf", 32'(of), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            rnd_inputs();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov), 32'(0));
        chk("midrst_in_ready", 32'(ir), 32'hF);
        chk("midrst_sum", 32'(sum0), 32'(0));
        repeat (3) begin
            @(negedge clk);
            chk("in_reset_out_valid", 32'(ov), 32'(0));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_out_valid", 32'(ov), 32'(0));
        end
        foreach (tbl[t]) send_dir(tbl[t]);
        drain();
        base = n_out;
        sent = 0;
        for (int c = 0; c < 40 && (sent < 5 || n_out - base < 5); c++) begin
            @(posedge clk); #1;
            in_valid  = sent < 5;
            out_ready = c >= 4;
            rnd_inputs();
            @(negedge clk);
            if (c == 2) begin
                chk("bp_accepts_before_stall", 32'(sent), 32'(2));
                chk("bp_in_ready_low", 32'(ir[0]), 32'(0));
                chk("bp_out_valid", 32'(ov[0]), 32'(1));
                hold_s = sum0;
                hold_o = of[0];
            end
            if (c == 3) begin
                chk("bp_in_ready_low2", 32'(ir[0]), 32'(0));
                chk("bp_sum_stable", 32'(sum0), 32'(hold_s));
                chk("bp_ovf_stable", 32'(of[0]), 32'(hold_o));
            end
            if (in_valid && ir[0]) sent++;
        end
        #1 chk("bp_results", 32'(n_out - base), 32'(5));
        drain();
        base = n_out;
        stall = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            rnd_inputs();
            @(negedge clk);
            if (!ir[0]) stall++;
        end
        #1;
        chk("tput_stalls", 32'(stall), 32'(0));
        chk("tput_outputs", 32'(n_out - base), 32'(998));
        drain();
        base = n_out;
        acc = 0;
        both = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            out_ready = (c % 2) == 1;
            rnd_inputs();
            @(negedge clk);
            if (in_valid && ir[0]) acc++;
            if (in_valid && ir[0] && ov[0] && out_ready) both++;
        end
        drain();
        chk("toggle_count", 32'(n_out - base), 32'(acc));
        chk("toggle_overlap", 32'(both > 0), 32'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
